nand_cmd_decoder: RTL

- Sits directly downstream of the command receiver. Consumes its 32-bit command words, each qualified by a start_cmd pulse.
- Reassembles multi-word read, write and erase sequences into a single validated operation request for the NAND flash controller core.
- Hands that request off over a valid/ready handshake.
- Flags malformed, out-of-order, timed-out or dropped sequences through an error pulse and code.

---
 rtl/nand_cmd_pkg.sv | 48 ++++
 rtl/cmd_word_capture.sv | 25 ++
 rtl/nand_cmd_decoder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/nand_cmd_pkg.sv
// Shared definitions for the NAND command decoder: opcodes, operation
// encodings, error causes, FSM states and the request record.
package nand_cmd_pkg;

    localparam logic [7:0] OP_READ  = 8'hAD;
    localparam logic [7:0] OP_WADDR = 8'hAF;
    localparam logic [7:0] OP_WGO   = 8'hA0;
    localparam logic [7:0] OP_ERASE = 8'hAE;

    localparam logic [1:0] OPT_NONE  = 2'b00;
    localparam logic [1:0] OPT_READ  = 2'b01;
    localparam logic [1:0] OPT_WRITE = 2'b10;
    localparam logic [1:0] OPT_ERASE = 2'b11;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SEQ     = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_BUSY    = 3'd3;
    localparam logic [2:0] ERR_RANGE   = 3'd4;
    localparam logic [2:0] ERR_PAYLOAD = 3'd5;

    typedef enum logic [2:0] {
        IDLE, R_LO, W_LO, W_GO, E_SLO, E_EHI, E_ELO, ISSUE
    } state_e;

    typedef struct packed {
        logic [1:0]  op_type;
        logic [23:0] addr;
        logic [23:0] end_addr;
    } op_req_t;

    // AD00 / AF00 / AE00 open a new sequence
    function automatic logic is_start_word(input logic [31:0] w);
        return (w[23:16] == 8'h00) &&
               (w[31:24] == OP_READ || w[31:24] == OP_WADDR || w[31:24] == OP_ERASE);
    endfunction

    // first collecting state reached from a sequence-start opcode
    function automatic state_e start_state(input logic [7:0] opc);
        case (opc)
            OP_READ:  return R_LO;
            OP_WADDR: return W_LO;
            OP_ERASE: return E_SLO;
            default:  return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/cmd_word_capture.sv
// Rising-edge qualifier for the command bus: a start_cmd level yields exactly
// one accept strobe in its first high cycle, with cmd passed through that cycle.
module cmd_word_capture #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_cmd,
    input  logic [W-1:0] cmd,
    output logic         word_vld,
    output logic [W-1:0] word
);

    logic start_d;

    // previous-cycle copy of the qualifier for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) start_d <= 1'b0;
        else     start_d <= start_cmd;
    end

    assign word_vld = start_cmd & ~start_d;
    assign word     = cmd;

endmodule

// File: rtl/nand_cmd_decoder.sv
// Reassembles multi-word read/write/erase command sequences into a single
// validated operation request and hands it to the flash controller core.
module nand_cmd_decoder
    import nand_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        start_cmd,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [1:0]  op_type,
    output logic [23:0] op_addr,
    output logic [23:0] op_end_addr,
    output logic        busy,
    output logic        err_pulse,
    output logic [2:0]  err_code
);

    logic        word_vld;
    logic [31:0] word;

    cmd_word_capture #(.W(32)) u_cap (
        .clk       (clk),
        .rst       (rst),
        .start_cmd (start_cmd),
        .cmd       (cmd),
        .word_vld  (word_vld),
        .word      (word)
    );

    state_e          state, state_n;
    op_req_t         req, req_n;
    logic [15:0]     addr_hi, addr_hi_n, end_hi, end_hi_n;
    logic [7:0]      addr_lo, addr_lo_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic            err_p_n;
    logic [2:0]      err_c_n;
    logic            bad_seq;
    logic [23:0]     erase_end;

    wire [7:0]  opc = word[31:24];
    wire [7:0]  idx = word[23:16];
    wire [15:0] pay = word[15:0];
    wire collecting = (state != IDLE) && (state != ISSUE);

    // state, captured address fragments, request and error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            addr_hi   <= '0;
            addr_lo   <= '0;
            end_hi    <= '0;
            to_cnt    <= '0;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_n;
            req       <= req_n;
            addr_hi   <= addr_hi_n;
            addr_lo   <= addr_lo_n;
            end_hi    <= end_hi_n;
            to_cnt    <= to_cnt_n;
            err_pulse <= err_p_n;
            err_code  <= err_c_n;
        end
    end

    // sequence walk: timeout, handshake, per-state word checks, resync
    always_comb begin
        state_n   = state;
        req_n     = req;
        addr_hi_n = addr_hi;
        addr_lo_n = addr_lo;
        end_hi_n  = end_hi;
        to_cnt_n  = '0;
        err_p_n   = 1'b0;
        err_c_n   = err_code;
        bad_seq   = 1'b0;
        erase_end = {end_hi, pay[15:8]};

        // an accept in the terminal cycle wins, since the word path below
        // overrides state and the counter already defaults to cleared
        if (collecting && !word_vld) begin
            if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                state_n = IDLE;
                err_p_n = 1'b1;
                err_c_n = ERR_TIMEOUT;
            end else begin
                to_cnt_n = to_cnt + 1'b1;
            end
        end

        if (state == ISSUE && op_ready) state_n = IDLE;

        if (word_vld) begin
            case (state)
                IDLE: bad_seq = !is_start_word(word);
                R_LO: begin
                    if (opc == OP_READ && idx == 8'h01) begin
                        if (pay[7:0] != 8'h00) begin
                            state_n = IDLE; err_p_n = 1'b1; err_c_n = ERR_PAYLOAD;
                        end else begin
                            req_n.op_type  = OPT_READ;
                            req_n.addr     = {addr_hi, pay[15:8]};
                            req_n.end_addr = '0;
                            state_n        = ISSUE;
                        end
                    end else bad_seq = 1'b1;
                end
                W_LO: begin
                    if (opc == OP_WADDR && idx == 8'h01) begin
                        if (pay[7:0] != 8'h00) begin
                            state_n = IDLE; err_p_n = 1'b1; err_c_n = ERR_PAYLOAD;
                        end else begin
                            addr_lo_n = pay[15:8];
                            state_n   = W_GO;
                        end
                    end else bad_seq = 1'b1;
                end
                W_GO: begin
                    if (opc == OP_WGO && idx == 8'h00) begin
                        if (pay != 16'h0000) begin
                            state_n = IDLE; err_p_n = 1'b1; err_c_n = ERR_PAYLOAD;
                        end else begin
                            req_n.op_type  = OPT_WRITE;
                            req_n.addr     = {addr_hi, addr_lo};
                            req_n.end_addr = '0;
                            state_n        = ISSUE;
                        end
                    end else bad_seq = 1'b1;
                end
                E_SLO: begin
                    if (opc == OP_ERASE && idx == 8'h01) begin
                        if (pay[7:0] != 8'h00) begin
                            state_n = IDLE; err_p_n = 1'b1; err_c_n = ERR_PAYLOAD;
                        end else begin
                            addr_lo_n = pay[15:8];
                            state_n   = E_EHI;
                        end
                    end else bad_seq = 1'b1;
                end
                E_EHI: begin
                    if (opc == OP_ERASE && idx == 8'h02) begin
                        end_hi_n = pay;
                        state_n  = E_ELO;
                    end else bad_seq = 1'b1;
                end
                E_ELO: begin
                    if (opc == OP_ERASE && idx == 8'h03) begin
                        if (pay[7:0] != 8'h00) begin
                            state_n = IDLE; err_p_n = 1'b1; err_c_n = ERR_PAYLOAD;
                        end else if (erase_end < {addr_hi, addr_lo}) begin
                            state_n = IDLE; err_p_n = 1'b1; err_c_n = ERR_RANGE;
                        end else begin
                            req_n.op_type  = OPT_ERASE;
                            req_n.addr     = {addr_hi, addr_lo};
                            req_n.end_addr = erase_end;
                            state_n        = ISSUE;
                        end
                    end else bad_seq = 1'b1;
                end
                ISSUE: begin
                    // request held; the stray word is dropped
                    err_p_n = 1'b1;
                    err_c_n = ERR_BUSY;
                end
                default: state_n = IDLE;
            endcase

            if (bad_seq) begin
                state_n = IDLE;
                err_p_n = 1'b1;
                err_c_n = ERR_SEQ;
            end
            // a start word always opens a fresh sequence, even after an error
            if ((state == IDLE || bad_seq) && is_start_word(word)) begin
                state_n   = start_state(opc);
                addr_hi_n = pay;
            end
        end
    end

    assign op_valid    = (state == ISSUE);
    assign busy        = (state != IDLE);
    assign op_type     = req.op_type;
    assign op_addr     = req.addr;
    assign op_end_addr = req.end_addr;

endmodule
